// File: rtl/kb_buf_ctrl.sv
// rtl/kb_buf_ctrl.sv - circular FIFO sequencer for the single-port keyboard scan-code RAM
// Optional build macro: KB_BREAK_FILTER_EN (drops PS/2 break prefix F0 and its following byte)
module kb_buf_ctrl #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             kb_valid,
    input  logic [WIDTH-1:0] kb_data,
    input  logic             cpu_rd_req,
    output logic             cpu_rd_ack,
    output logic [WIDTH-1:0] cpu_rd_data,
    input  logic             cpu_clr,
    output logic             empty,
    output logic             full,
    output logic [DEPTH-1:0] count,
    output logic             overflow,
    output logic             ram_ena,
    output logic             ram_wena,
    output logic [DEPTH-1:0] ram_addr,
    output logic [WIDTH-1:0] ram_wdata,
    input  logic [WIDTH-1:0] ram_rdata
);
    // Top RAM address is the status word, so capacity is one short of the address space.
    localparam int CAP_I = (1 << DEPTH) - 1;
    localparam logic [DEPTH-1:0] CAP  = CAP_I[DEPTH-1:0];
    localparam logic [DEPTH-1:0] LAST = CAP - 1'b1;

    typedef enum logic [1:0] {S_IDLE, S_READ, S_ACK} state_t;

    state_t           state_q, state_d;
    logic [DEPTH-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, count_q, count_d;
    logic [WIDTH-1:0] hold_q, hold_d, rd_data_q, rd_data_d;
    logic             hold_v_q, hold_v_d, overflow_q, overflow_d;
    logic             wr_slot, kb_take;

`ifdef KB_BREAK_FILTER_EN
    logic brk_pend_q, brk_pend_d;

    always_comb begin
        brk_pend_d = brk_pend_q;
        kb_take    = 1'b0;
        if (kb_valid) begin
            if (brk_pend_q) begin
                brk_pend_d = 1'b0;
            end else if (kb_data == WIDTH'(8'hF0)) begin
                brk_pend_d = 1'b1;
            end else begin
                kb_take = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst || cpu_clr) brk_pend_q <= 1'b0;
        else                brk_pend_q <= brk_pend_d;
    end
`else
    always_comb kb_take = kb_valid;
`endif

    always_comb begin
        state_d    = state_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        hold_d     = hold_q;
        hold_v_d   = hold_v_q;
        rd_data_d  = rd_data_q;
        overflow_d = overflow_q;
        ram_ena    = 1'b0;
        ram_wena   = 1'b0;
        ram_addr   = '0;
        ram_wdata  = hold_q;
        wr_slot    = hold_v_q && (state_q != S_READ);

        if (wr_slot) begin
            ram_ena  = 1'b1;
            ram_addr = wr_ptr_q;
            hold_v_d = 1'b0;
            if (count_q != CAP) begin
                ram_wena = 1'b1;
                wr_ptr_d = (wr_ptr_q == LAST) ? '0 : wr_ptr_q + 1'b1;
                count_d  = count_q + 1'b1;
            end else begin
                overflow_d = 1'b1;
            end
        end

        case (state_q)
            S_IDLE: if (cpu_rd_req && !hold_v_q) state_d = S_READ;
            S_READ: begin
                ram_ena  = 1'b1;
                ram_addr = rd_ptr_q;
                if (count_q != '0) begin
                    rd_data_d = ram_rdata;
                    rd_ptr_d  = (rd_ptr_q == LAST) ? '0 : rd_ptr_q + 1'b1;
                    count_d   = count_q - 1'b1;
                end else begin
                    rd_data_d = '0;
                end
                state_d = S_ACK;
            end
            S_ACK:  if (!cpu_rd_req) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        // The hold register can accept a new code in the same cycle it drains into RAM.
        if (kb_take) begin
            if (!hold_v_q || wr_slot) begin
                hold_d   = kb_data;
                hold_v_d = 1'b1;
            end else begin
                overflow_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst || cpu_clr) begin
            state_q    <= S_IDLE;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            hold_q     <= '0;
            hold_v_q   <= 1'b0;
            overflow_q <= 1'b0;
            if (rst) rd_data_q <= '0;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            hold_q     <= hold_d;
            hold_v_q   <= hold_v_d;
            overflow_q <= overflow_d;
            rd_data_q  <= rd_data_d;
        end
    end

    assign cpu_rd_ack  = (state_q == S_ACK);
    assign cpu_rd_data = rd_data_q;
    assign empty       = (count_q == '0);
    assign full        = (count_q == CAP);
    assign count       = count_q;
    assign overflow    = overflow_q;
endmodule
